// File: rtl/data_path_pkg.sv
// Shared opcode map, widths and the register-write decode for the data_path slice.
package data_path_pkg;

  localparam int DATA_W    = 8;
  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NOT  = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8,
    OP_LDI  = 4'h9,
    OP_ADDI = 4'hA
  } opcode_e;

  // Every defined opcode except NOP stores its result; undefined codes are inert.
  function automatic logic op_writes_reg(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_ADDI);
  endfunction

endpackage

// File: rtl/data_path_alu.sv
// Purely combinational ALU; NOP and undefined opcodes produce zero.
module alu
  import data_path_pkg::*;
#(
  parameter int W = data_path_pkg::DATA_W
) (
  input  logic [3:0]   opcode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] imm,
  output logic [W-1:0] result
);

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  result = {a[W-2:0], 1'b0};
      OP_SHR:  result = {1'b0, a[W-1:1]};
      OP_LDI:  result = imm;
      OP_ADDI: result = a + imm;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/data_path.sv
// Register file plus ALU: one operation per clock, result registered on ALUResult.
module data_path
  import data_path_pkg::*;
#(
  parameter int DATA_W   = data_path_pkg::DATA_W,
  parameter int NUM_REGS = data_path_pkg::NUM_REGS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           Opcode,
  input  logic [REG_IDX_W-1:0] SrcReg1,
  input  logic [REG_IDX_W-1:0] SrcReg2,
  input  logic [REG_IDX_W-1:0] DestReg,
  input  logic [DATA_W-1:0]    Immediate,
  output logic [DATA_W-1:0]    ALUResult
);

  logic [DATA_W-1:0]   regs_reg [NUM_REGS];
  logic [DATA_W-1:0]   result_reg;
  logic [DATA_W-1:0]   operand_a;
  logic [DATA_W-1:0]   operand_b;
  logic [DATA_W-1:0]   result_next;
  logic                wr_en;
  logic [NUM_REGS-1:0] wr_sel;

  // Reads see only the pre-edge contents, so DestReg == SrcReg uses the old value.
  assign operand_a = regs_reg[SrcReg1];
  assign operand_b = regs_reg[SrcReg2];
  assign wr_en     = op_writes_reg(Opcode);

  alu #(.W(DATA_W)) u_alu (
    .opcode (Opcode),
    .a      (operand_a),
    .b      (operand_b),
    .imm    (Immediate),
    .result (result_next)
  );

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en && (DestReg == REG_IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
      result_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) begin
          regs_reg[i] <= result_next;
        end
      end
      result_reg <= result_next;
    end
  end

  assign ALUResult = result_reg;

endmodule

// File: tb/tb_data_path.sv
// Directed plus randomized check of data_path against an arithmetic reference model.
module tb_data_path;

  logic       clk;
  logic       rst_n;
  logic [3:0] Opcode;
  logic [2:0] SrcReg1;
  logic [2:0] SrcReg2;
  logic [2:0] DestReg;
  logic [7:0] Immediate;
  logic [7:0] ALUResult;

  int vectors;
  int miscompares;
  int model_regs [8];

  data_path dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Opcode    (Opcode),
    .SrcReg1   (SrcReg1),
    .SrcReg2   (SrcReg2),
    .DestReg   (DestReg),
    .Immediate (Immediate),
    .ALUResult (ALUResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour from the opcode table, using plain integer arithmetic mod 256.
  function automatic int model_alu(input int op, input int a, input int b, input int imm);
    int r;
    case (op)
      1:       r = a + b;
      2:       r = a - b + 256;
      3:       r = a & b;
      4:       r = a | b;
      5:       r = a ^ b;
      6:       r = 255 - a;
      7:       r = a * 2;
      8:       r = a / 2;
      9:       r = imm;
      10:      r = a + imm;
      default: r = 0;
    endcase
    return r % 256;
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, observed, expected);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model_regs[i] = 0;
  endtask

  // One operation: drive at the falling edge, sample 1 ns after the rising edge.
  task automatic op(input int opc, input int d, input int s1, input int s2, input int imm,
                    input int spec, input string tag);
    int exp_val;
    @(negedge clk);
    Opcode    = 4'(opc);
    DestReg   = 3'(d);
    SrcReg1   = 3'(s1);
    SrcReg2   = 3'(s2);
    Immediate = 8'(imm);
    exp_val   = model_alu(opc, model_regs[s1], model_regs[s2], imm);
    @(posedge clk);
    #1;
    check(tag, int'(ALUResult), exp_val);
    if (spec >= 0) check({tag, "_spec"}, int'(ALUResult), spec);
    if (opc >= 1 && opc <= 10) model_regs[d] = exp_val;
  endtask

  task automatic readback_all(input string tag);
    for (int n = 0; n < 8; n++) begin
      op(4, n, n, n, 0, -1, $sformatf("%s_r%0d", tag, n));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clear_model();
    Opcode = '0; SrcReg1 = '0; SrcReg2 = '0; DestReg = '0; Immediate = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_alu", int'(ALUResult), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load and add
    op(9, 0, 0, 0, 8'h10, 8'h10, "ldi_r0");
    op(9, 1, 0, 0, 8'h03, 8'h03, "ldi_r1");
    op(1, 2, 0, 1, 0,     8'h13, "add_r2");
    op(2, 3, 2, 1, 0,     8'h10, "sub_r3");

    // Logic
    op(3, 4, 3, 0, 0, 8'h10, "and_r4");
    op(4, 5, 4, 1, 0, 8'h13, "or_r5");
    op(5, 6, 0, 1, 0, 8'h13, "xor");
    op(6, 7, 1, 0, 0, 8'hFC, "not");
    op(7, 7, 1, 0, 0, 8'h06, "shl");
    op(8, 7, 0, 0, 0, 8'h08, "shr");

    // Wrap-around
    op(9,  6, 0, 0, 8'hFF, 8'hFF, "ldi_r6");
    op(10, 6, 6, 0, 8'h01, 8'h00, "addi_wrap");
    op(2,  7, 6, 1, 0,     8'hFD, "sub_borrow");

    // No-write opcodes leave R2 untouched
    op(0,  2, 0, 1, 8'h55, 8'h00, "nop");
    op(15, 2, 0, 1, 8'h55, 8'h00, "op_f");
    op(11, 2, 0, 1, 8'h55, 8'h00, "op_b");
    op(4,  5, 2, 2, 0,     8'h13, "r2_kept");
    op(1,  2, 2, 2, 0,     8'h26, "add_self");
    op(4,  5, 2, 2, 0,     8'h26, "add_self_stored");

    // Asynchronous reset asserted mid-cycle
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_alu", int'(ALUResult), 0);
    clear_model();
    @(posedge clk);
    #1;
    check("reset_hold_alu", int'(ALUResult), 0);
    @(negedge clk);
    rst_n = 1'b1;
    readback_all("post_reset");

    // Reset pulsed between two ADDs; in-flight op held across an edge is discarded
    op(9, 0, 0, 0, 8'h05, 8'h05, "ldi_a");
    op(9, 1, 0, 0, 8'h06, 8'h06, "ldi_b");
    op(1, 2, 0, 1, 0,     8'h0B, "add_pre");
    @(negedge clk);
    Opcode = 4'd1; DestReg = 3'd3; SrcReg1 = 3'd0; SrcReg2 = 3'd1; Immediate = 8'h00;
    rst_n = 1'b0;
    #1;
    check("pulse_alu", int'(ALUResult), 0);
    clear_model();
    @(posedge clk);
    #1;
    check("inflight_alu", int'(ALUResult), 0);
    @(negedge clk);
    rst_n = 1'b1;
    op(1, 3, 0, 1, 0, 8'h00, "add_post");
    readback_all("mid_reset");

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      op(int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
         int'($urandom_range(0, 255)), -1, $sformatf("rand%0d", k));
    end
    readback_all("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_path.md
DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 Parameter: DATA_W, 8, datapath and register width.
REQ-002 Parameter: NUM_REGS, 8, register-file depth; register index width is 3 bits.
REQ-003 Port: clk  input  1  single rising-edge clock for all state.
REQ-004 Port: rst_n  input  1  reset; one clock, and reset is asynchronous and active-low.
REQ-005 Port: Opcode  input  4  operation select, sampled every cycle.
REQ-006 Port: SrcReg1  input  3  register index of operand A.
REQ-007 Port: SrcReg2  input  3  register index of operand B.
REQ-008 Port: DestReg  input  3  register index written with the result.
REQ-009 Port: Immediate  input  8  immediate operand for LDI and ADDI.
REQ-010 Port: ALUResult  output  8  registered result of the operation sampled at the last rising edge.

Function
REQ-011 The block SHALL hold an 8x8 register file R0..R7; R0 is an ordinary writable register, not hardwired to zero.
REQ-012 Operand reads SHALL be combinational: A = R[SrcReg1], B = R[SrcReg2], with no write bypass.
REQ-013 Opcode map SHALL be: 0000 NOP; 0001 ADD A+B; 0010 SUB A-B; 0011 AND; 0100 OR; 0101 XOR; 0110 NOT A; 0111 SHL A by 1; 1000 SHR A by 1 (logical); 1001 LDI (result = Immediate); 1010 ADDI A+Immediate.
REQ-014 Arithmetic SHALL be unsigned modulo 2^8; carry and borrow are discarded (0xFF+0x01 = 0x00, 0x00-0x01 = 0xFF).
REQ-015 At each rising edge with rst_n high, ALUResult SHALL be loaded with the computed result; latency is one clock from input sampling to output.
REQ-016 At the same edge, opcodes 0001..1010 SHALL write the result into R[DestReg]; NOP and 1011..1111 SHALL NOT write any register.
REQ-017 For NOP and 1011..1111, ALUResult SHALL be loaded with 0x00.
REQ-018 When DestReg equals SrcReg1 or SrcReg2, the operation SHALL use the pre-edge value and store the new value.
REQ-019 Back-to-back dependent operations SHALL see the previous cycle's write with no stall.
REQ-020 Inputs SHALL be held stable around the rising edge by the driver; no handshake exists, and one operation is executed every cycle.

Reset
REQ-021 While rst_n is low, all registers R0..R7 and ALUResult SHALL be 0x00, independent of clk.
REQ-022 Reset assertion in the middle of a sequence SHALL discard the in-flight operation, with no register write.
REQ-023 The first operation after deassertion SHALL execute at the first rising edge on which rst_n is high.

Structure
REQ-024 A shared package SHALL hold the 4-bit opcode constants, DATA_W and the register index width.
REQ-025 A single combinational sub-module named alu SHALL compute the result from opcode, A, B and Immediate.
REQ-026 The register file and ALUResult register SHALL reside in data_path; target size is 120-400 RTL lines.

Verification
REQ-027 Reset test: assert rst_n low mid-cycle -> ALUResult = 0x00 immediately; all registers read 0x00 afterwards (check via OR Rn,Rn).
REQ-028 Load and add test: LDI R0=0x10, then LDI R1=0x03, then ADD R2=R0+R1 -> ALUResult 0x13 one cycle later; then SUB R3=R2-R1 -> 0x10.
REQ-029 Logic test: with R0=0x10 and R1=0x03:
- AND R4=R3,R0 -> 0x10
- OR R5=R4,R1 -> 0x13
- XOR R0,R1 -> 0x13
- NOT R1 -> 0xFC
- SHL R1 -> 0x06
- SHR R0 -> 0x08
REQ-030 Wrap test:
- LDI R6=0xFF, then ADDI R6,0x01 -> 0x00
- SUB R7=R6-R1, with R6=0x00 and R1=0x03 -> 0xFD
REQ-031 No-write test:
- Opcode 0000 or 1111 with DestReg=R2 -> ALUResult 0x00; R2 keeps 0x13.
- ADD R2=R2,R2 -> 0x26, using the old R2 value.
REQ-032 Mid-sequence reset test: pulse rst_n low between two ADDs -> the second ADD reads zeros and produces 0x00.
